// File: rtl/blackjack_round.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : blackjack_round                                              |
// | Description : Round controller for the BlackJack game. Maps the upstream   |
// |               5-bit random value to card values, runs the deal / hit /     |
// |               stand / dealer-draw sequence from the push-button keys and   |
// |               reports the one-hot round result.                            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
// | Ports                                                                      |
// |   Clock    in   1  system clock                                            |
// |   reset_n  in   1  asynchronous active-low reset                           |
// |   randnum  in   5  random value, sampled at each draw                      |
// |   deal_n   in   1  raw active-low key: start a new round                   |
// |   hit_n    in   1  raw active-low key: player takes a card                 |
// |   stand_n  in   1  raw active-low key: player stands                       |
// |   phand    out  5  player hand total                                       |
// |   dhand    out  5  dealer hand total                                       |
// |   fsm_out  out  5  one-hot result (0 while no result)                      |
// |   state    out  3  current state code                                      |
// |   busy     out  1  high while cards are drawn automatically                |
// +----------------------------------------------------------------------------+
module blackjack_round #(
   parameter int DRAW_GAP     = 16,
   parameter int DEALER_STAND = 17
) (
   input  logic       Clock,
   input  logic       reset_n,
   input  logic [4:0] randnum,
   input  logic       deal_n,
   input  logic       hit_n,
   input  logic       stand_n,
   output logic [4:0] phand,
   output logic [4:0] dhand,
   output logic [4:0] fsm_out,
   output logic [2:0] state,
   output logic       busy
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DEAL   = 3'd1,
      S_PLAYER = 3'd2,
      S_DEALER = 3'd3,
      S_RESULT = 3'd4
   } state_t;

   localparam int                 c_GAP_W     = $clog2(DRAW_GAP);
   localparam logic [c_GAP_W-1:0] c_GAP_LAST  = c_GAP_W'(DRAW_GAP - 1);
   localparam logic [5:0]         c_STAND     = 6'(DEALER_STAND);
   localparam logic [4:0]         c_LIMIT     = 5'd21;
   localparam logic [4:0]         c_RES_PHI   = 5'b00001;
   localparam logic [4:0]         c_RES_DHI   = 5'b00010;
   localparam logic [4:0]         c_RES_PUSH  = 5'b00100;
   localparam logic [4:0]         c_RES_PBUST = 5'b01000;
   localparam logic [4:0]         c_RES_DBUST = 5'b10000;

   state_t               r_state;
   logic [4:0]           r_phand;
   logic [4:0]           r_dhand;
   logic [4:0]           r_fsm;
   logic                 r_busy;
   logic [c_GAP_W-1:0]   r_gap;
   logic [1:0]           r_draws;

   logic [2:0]           w_key_n;
   logic [2:0]           w_press;
   logic                 w_deal;
   logic                 w_hit;
   logic                 w_stand;
   logic                 w_gap_hit;
   logic [4:0]           w_mod;
   logic [4:0]           w_rank;
   logic [4:0]           w_card;
   logic [4:0]           w_pnext;
   logic [4:0]           w_dnext;

   // ---------------------------------------------------------------------
   // Key conditioning: two synchronizer flops, a history flop, and a
   // registered falling-edge pulse. Holding a key yields one pulse only.
   // Flops clear to 0, so the keys idling high after reset only ever rise.
   // ---------------------------------------------------------------------
   assign w_key_n = {stand_n, hit_n, deal_n};

   for (genvar i = 0; i < 3; i++) begin : g_key
      logic r_sync1;
      logic r_sync2;
      logic r_hist;
      logic r_pulse;

      always_ff @(posedge Clock or negedge reset_n) begin
         if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_hist  <= 1'b0;
            r_pulse <= 1'b0;
         end else begin
            r_sync1 <= w_key_n[i];
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_pulse <= r_hist & ~r_sync2;
         end
      end

      assign w_press[i] = r_pulse;
   end

   assign w_deal  = w_press[0];
   assign w_hit   = w_press[1];
   assign w_stand = w_press[2];

   // ---------------------------------------------------------------------
   // Card mapping: 0 is an ace; otherwise rank 1..13 from r mod 13 with
   // 0 standing for the king, and face cards capped at 10.
   // ---------------------------------------------------------------------
   always_comb begin
      w_mod  = randnum % 5'd13;
      w_rank = (w_mod == 5'd0) ? 5'd13 : w_mod;
      if (randnum == 5'd0) begin
         w_card = 5'd1;
      end else if (w_rank > 5'd10) begin
         w_card = 5'd10;
      end else begin
         w_card = w_rank;
      end
   end

   // Hands cannot exceed 31 in play; saturation is purely defensive.
   function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [4:0] b);
      logic [5:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[5] ? 5'd31 : sum[4:0];
   endfunction

   assign w_pnext   = sat_add(r_phand, w_card);
   assign w_dnext   = sat_add(r_dhand, w_card);
   assign w_gap_hit = (r_gap == c_GAP_LAST);

   // ---------------------------------------------------------------------
   // Round sequencer. The gap counter free-runs and is re-zeroed when a
   // round starts and when the player stands, so automatic draws land
   // DRAW_GAP cycles after those events.
   // ---------------------------------------------------------------------
   always_ff @(posedge Clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_phand <= 5'd0;
         r_dhand <= 5'd0;
         r_fsm   <= 5'd0;
         r_busy  <= 1'b0;
         r_gap   <= '0;
         r_draws <= 2'd0;
      end else begin
         r_gap <= w_gap_hit ? '0 : r_gap + 1'b1;

         case (r_state)
            S_IDLE, S_RESULT: begin
               if (w_deal) begin
                  r_phand <= 5'd0;
                  r_dhand <= 5'd0;
                  r_fsm   <= 5'd0;
                  r_gap   <= '0;
                  r_draws <= 2'd0;
                  r_state <= S_DEAL;
                  r_busy  <= 1'b1;
               end
            end

            S_DEAL: begin
               if (w_gap_hit) begin
                  // Even draws go to the player, odd draws to the dealer.
                  if (!r_draws[0]) begin
                     r_phand <= w_pnext;
                  end else begin
                     r_dhand <= w_dnext;
                  end
                  r_draws <= r_draws + 2'd1;
                  if (r_draws == 2'd3) begin
                     r_state <= S_PLAYER;
                     r_busy  <= 1'b0;
                  end
               end
            end

            S_PLAYER: begin
               // Stand takes priority over a simultaneous hit.
               if (w_stand) begin
                  r_gap   <= '0;
                  r_state <= S_DEALER;
                  r_busy  <= 1'b1;
               end else if (w_hit && (r_phand < c_LIMIT)) begin
                  r_phand <= w_pnext;
                  if (w_pnext > c_LIMIT) begin
                     r_fsm   <= c_RES_PBUST;
                     r_state <= S_RESULT;
                  end
               end
            end

            S_DEALER: begin
               if (w_gap_hit) begin
                  if ({1'b0, r_dhand} < c_STAND) begin
                     r_dhand <= w_dnext;
                     if (w_dnext > c_LIMIT) begin
                        r_fsm   <= c_RES_DBUST;
                        r_state <= S_RESULT;
                        r_busy  <= 1'b0;
                     end
                  end else begin
                     if (r_phand > r_dhand) begin
                        r_fsm <= c_RES_PHI;
                     end else if (r_phand < r_dhand) begin
                        r_fsm <= c_RES_DHI;
                     end else begin
                        r_fsm <= c_RES_PUSH;
                     end
                     r_state <= S_RESULT;
                     r_busy  <= 1'b0;
                  end
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign phand   = r_phand;
   assign dhand   = r_dhand;
   assign fsm_out = r_fsm;
   assign state   = r_state;
   assign busy    = r_busy;

endmodule
`default_nettype wire
